// File: rtl/pipe_elastic_stage_reg_pkg.sv
// Shared constants and state encoding for the elastic pipeline register.
// Occupancy encodings double as the occupancy output value.
package pipe_elastic_stage_reg_pkg;

   localparam int          PC_W_DEF      = 32;
   localparam int          INSTR_W_DEF   = 32;
   localparam int          SIDE_W_DEF    = 4;
   localparam int          CNT_W_DEF     = 16;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_elastic_stage_reg_if.sv
// Valid/ready beat carrying pc, instruction and sideband bits.
// The master drives the beat and the slave returns ready.
interface pipe_elastic_stage_reg_if
   import pipe_elastic_stage_reg_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int SIDE_W  = SIDE_W_DEF
) ();

   logic               valid;
   logic               ready;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;
   logic [SIDE_W-1:0]  side;

   modport master (
      output valid,
      output pc,
      output instr,
      output side,
      input  ready
   );

   modport slave (
      input  valid,
      input  pc,
      input  instr,
      input  side,
      output ready
   );

endinterface

// File: rtl/pipe_elastic_stage_reg_slot.sv
// One payload register plus its valid bit; clear wins over load.
// Only the valid bit is reset, the payload is qualified by it downstream.
module pipe_skid_slot #(
   parameter int W = 68
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic         vld_o
);

   logic         vld_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= 1'b0;
      end else if (clear_i) begin
         vld_q <= 1'b0;
      end else if (load_i) begin
         vld_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (load_i) begin
         data_q <= d_i;
      end
   end

   assign q_o   = data_q;
   assign vld_o = vld_q;

endmodule

// File: rtl/pipe_elastic_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer and registered in_ready.
// Empty head presents a NOP payload; idle output cycles feed a saturating counter.
module pipe_elastic_stage_reg
   import pipe_elastic_stage_reg_pkg::*;
#(
   parameter int                 PC_W      = PC_W_DEF,
   parameter int                 INSTR_W   = INSTR_W_DEF,
   parameter int                 SIDE_W    = SIDE_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
   parameter int                 CNT_W     = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   pipe_elastic_stage_reg_if.slave  up_if,
   pipe_elastic_stage_reg_if.master dn_if,
   output logic                    out_bubble_o,
   output logic [1:0]              occupancy_o,
   output logic [CNT_W-1:0]        bubble_cnt_o
);

   localparam int PAY_W = PC_W + INSTR_W + SIDE_W;

   occ_e             state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;

   logic             acc_in, acc_out;
   logic             main_load, main_clr, main_sel_skid;
   logic             skid_load, skid_clr;
   logic             main_vld, skid_vld;
   logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign in_pay  = {up_if.pc, up_if.instr, up_if.side};
   assign acc_in  = up_if.valid & in_ready_q;
   assign acc_out = main_vld & dn_if.ready;
   assign main_d  = main_sel_skid ? skid_q : in_pay;

   // Next-state and slot control; flush overrides any transfer this cycle
   always_comb begin
      state_d       = state_q;
      main_load     = 1'b0;
      main_clr      = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      if (flush_i) begin
         state_d  = OCC_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (acc_in) begin
                  main_load = 1'b1;
                  state_d   = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (acc_in && acc_out) begin
                  main_load = 1'b1;
               end else if (acc_in) begin
                  skid_load = 1'b1;
                  state_d   = OCC_FULL;
               end else if (acc_out) begin
                  main_clr = 1'b1;
                  state_d  = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (acc_out) begin
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
                  skid_clr      = 1'b1;
                  state_d       = OCC_ONE;
               end
            end
            default: begin
               main_clr = 1'b1;
               skid_clr = 1'b1;
               state_d  = OCC_EMPTY;
            end
         endcase
      end
      in_ready_d = (state_d != OCC_FULL);
      bcnt_d     = main_vld ? bcnt_q : sat_inc(bcnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= OCC_EMPTY;
         in_ready_q <= 1'b1;
         bcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         bcnt_q     <= bcnt_d;
      end
   end

   pipe_skid_slot #(.W(PAY_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load_i  (main_load),
      .clear_i (main_clr),
      .d_i     (main_d),
      .q_o     (main_q),
      .vld_o   (main_vld)
   );

   pipe_skid_slot #(.W(PAY_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .d_i     (in_pay),
      .q_o     (skid_q),
      .vld_o   (skid_vld)
   );

   // Head payload is gated by the registered valid bit, never by out_ready
   assign up_if.ready  = in_ready_q;
   assign dn_if.valid  = main_vld;
   assign dn_if.pc     = main_vld ? main_q[PAY_W-1 -: PC_W]     : '0;
   assign dn_if.instr  = main_vld ? main_q[SIDE_W +: INSTR_W]   : NOP_INSTR;
   assign dn_if.side   = main_vld ? main_q[SIDE_W-1:0]          : '0;
   assign out_bubble_o = ~main_vld;
   assign occupancy_o  = state_q;
   assign bubble_cnt_o = bcnt_q;

   logic unused_skid_vld;
   assign unused_skid_vld = skid_vld;

endmodule

// File: tb/tb_pipe_elastic_stage_reg.sv
// Directed and randomized checks of the elastic stage register with CNT_W=4.
// Random phase scores beats against a flush-aware reference queue.
module tb_pipe_elastic_stage_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       bubble;
   logic [1:0] occ;
   logic [3:0] bcnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] q[$];
   logic [31:0] head;
   logic [31:0] pc_nxt;
   int          n;
   bit          acc;

   pipe_elastic_stage_reg_if #(.PC_W(32), .INSTR_W(32), .SIDE_W(4)) up_if ();
   pipe_elastic_stage_reg_if #(.PC_W(32), .INSTR_W(32), .SIDE_W(4)) dn_if ();

   pipe_elastic_stage_reg #(
      .PC_W      (32),
      .INSTR_W   (32),
      .SIDE_W    (4),
      .NOP_INSTR (32'h0000_0013),
      .CNT_W     (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .up_if        (up_if.slave),
      .dn_if        (dn_if.master),
      .out_bubble_o (bubble),
      .occupancy_o  (occ),
      .bubble_cnt_o (bcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] pc);
      up_if.valid = v;
      up_if.pc    = pc;
      up_if.instr = pc ^ 32'hDEAD_0000;
      up_if.side  = pc[5:2];
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_vld"},   64'(dn_if.valid), 64'd0);
      chk({tag, "_pc"},    64'(dn_if.pc), 64'd0);
      chk({tag, "_instr"}, 64'(dn_if.instr), 64'h13);
      chk({tag, "_side"},  64'(dn_if.side), 64'd0);
      chk({tag, "_bub"},   64'(bubble), 64'd1);
      chk({tag, "_rdy"},   64'(up_if.ready), 64'd1);
      chk({tag, "_occ"},   64'(occ), 64'd0);
      chk({tag, "_cnt"},   64'(bcnt), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      offer(1'b0, 32'h0);
      dn_if.ready = 1'b0;
      cyc();
      cyc();
      chk_reset_vals("rst0");
      rst = 1'b0;

      // T2 streaming
      offer(1'b1, 32'h0);
      dn_if.ready = 1'b1;
      cyc();
      chk("t2_pc0", 64'(dn_if.pc), 64'h0);
      chk("t2_vld0", 64'(dn_if.valid), 64'd1);
      chk("t2_instr0", 64'(dn_if.instr), 64'hDEAD_0000);
      chk("t2_cnt0", 64'(bcnt), 64'd1);
      offer(1'b1, 32'h4);
      cyc();
      chk("t2_pc4", 64'(dn_if.pc), 64'h4);
      chk("t2_occ4", 64'(occ), 64'd1);
      chk("t2_side4", 64'(dn_if.side), 64'h1);
      offer(1'b1, 32'h8);
      cyc();
      chk("t2_pc8", 64'(dn_if.pc), 64'h8);
      chk("t2_occ8", 64'(occ), 64'd1);
      offer(1'b0, 32'h0);
      cyc();
      chk("t2_drain", 64'(dn_if.valid), 64'd0);
      chk("t2_cnt", 64'(bcnt), 64'd1);
      cyc();
      chk("t2_cnt2", 64'(bcnt), 64'd2);

      // T3 backpressure
      dn_if.ready = 1'b0;
      offer(1'b1, 32'h10);
      cyc();
      chk("t3_occ1", 64'(occ), 64'd1);
      chk("t3_rdy1", 64'(up_if.ready), 64'd1);
      chk("t3_pc1", 64'(dn_if.pc), 64'h10);
      offer(1'b1, 32'h14);
      cyc();
      chk("t3_occ2", 64'(occ), 64'd2);
      chk("t3_rdy2", 64'(up_if.ready), 64'd0);
      offer(1'b1, 32'h18);
      cyc();
      chk("t3_hold_occ", 64'(occ), 64'd2);
      chk("t3_hold_pc", 64'(dn_if.pc), 64'h10);
      offer(1'b0, 32'h0);
      dn_if.ready = 1'b1;
      cyc();
      chk("t3_drain1_pc", 64'(dn_if.pc), 64'h14);
      chk("t3_drain1_rdy", 64'(up_if.ready), 64'd1);
      chk("t3_drain1_occ", 64'(occ), 64'd1);
      cyc();
      chk("t3_drain2_vld", 64'(dn_if.valid), 64'd0);
      chk("t3_drain2_occ", 64'(occ), 64'd0);
      chk("t3_cnt", 64'(bcnt), 64'd3);

      // T4 flush on a full stage
      dn_if.ready = 1'b0;
      offer(1'b1, 32'h30);
      cyc();
      offer(1'b1, 32'h34);
      cyc();
      chk("t4_full", 64'(occ), 64'd2);
      flush = 1'b1;
      offer(1'b1, 32'h20);
      cyc();
      flush = 1'b0;
      offer(1'b0, 32'h0);
      chk("t4_vld", 64'(dn_if.valid), 64'd0);
      chk("t4_instr", 64'(dn_if.instr), 64'h13);
      chk("t4_pc", 64'(dn_if.pc), 64'h0);
      chk("t4_bub", 64'(bubble), 64'd1);
      chk("t4_occ", 64'(occ), 64'd0);
      chk("t4_rdy", 64'(up_if.ready), 64'd1);
      cyc();
      chk("t4_no20", 64'(dn_if.valid), 64'd0);
      chk("t4_cnt", 64'(bcnt), 64'd5);

      // T1 asynchronous reset while full
      offer(1'b1, 32'h40);
      cyc();
      offer(1'b1, 32'h44);
      cyc();
      chk("t1_full", 64'(occ), 64'd2);
      #2;
      rst = 1'b1;
      offer(1'b0, 32'h0);
      #1;
      chk_reset_vals("t1");
      cyc();
      rst = 1'b0;

      // T5 bubble counter saturation
      cyc();
      cyc();
      cyc();
      chk("t5_cnt3", 64'(bcnt), 64'd3);
      for (int i = 0; i < 17; i++) cyc();
      chk("t5_sat", 64'(bcnt), 64'd15);
      dn_if.ready = 1'b1;
      offer(1'b1, 32'h50);
      cyc();
      offer(1'b1, 32'h54);
      cyc();
      cyc();
      chk("t5_traffic_cnt", 64'(bcnt), 64'd15);
      chk("t5_traffic_vld", 64'(dn_if.valid), 64'd1);
      offer(1'b0, 32'h0);
      cyc();
      chk("t5_empty", 64'(occ), 64'd0);

      // T6 randomized traffic against a reference queue
      pc_nxt = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         n = q.size();
         head = (n > 0) ? q[0] : 32'h0;
         chk("t6_vld", 64'(dn_if.valid), 64'(n > 0));
         chk("t6_occ", 64'(occ), 64'(n));
         chk("t6_rdy", 64'(up_if.ready), 64'(n != 2));
         chk("t6_pc", 64'(dn_if.pc), 64'(head));
         chk("t6_instr", 64'(dn_if.instr), (n > 0) ? 64'(head ^ 32'hDEAD_0000) : 64'h13);
         chk("t6_side", 64'(dn_if.side), (n > 0) ? 64'(head[5:2]) : 64'd0);
         offer($urandom_range(0, 99) < 70, pc_nxt);
         dn_if.ready = $urandom_range(0, 99) < 60;
         flush = $urandom_range(0, 99) < 4;
         pc_nxt = pc_nxt + 32'h4;
         acc = up_if.valid && (n < 2);
         cyc();
         if (flush) begin
            q.delete();
         end else begin
            if (dn_if.ready && n > 0) void'(q.pop_front());
            if (acc) q.push_back(up_if.pc);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
